// File: rtl/pid_out_pkg.sv
// Shared widths, channel FSM states and the command saturation helper for the
// PID output processor.
package pid_out_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int CHN_WIDTH  = 3;
    localparam int PWM_WIDTH  = 10;

    typedef enum logic {
        RUN  = 1'b0,
        DEAD = 1'b1
    } chn_state_e;

    // |d| clamped to lim; the 17-bit magnitude lets -32768 saturate cleanly.
    function automatic logic [PWM_WIDTH-1:0] sat_abs(input logic [DATA_WIDTH-1:0] d,
                                                     input logic [PWM_WIDTH-1:0]  lim);
        logic [DATA_WIDTH:0] mag;
        mag = d[DATA_WIDTH-1] ? ({1'b0, ~d} + (DATA_WIDTH+1)'(1)) : {1'b0, d};
        if (mag > {{(DATA_WIDTH+1-PWM_WIDTH){1'b0}}, lim})
            return lim;
        return mag[PWM_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/pid_output_processor_if.sv
// Command stream from the time-multiplexed PID core: strobe, channel, signed word.
interface pid_output_processor_if;
    import pid_out_pkg::*;

    logic                  pid_valid_i;
    logic [CHN_WIDTH-1:0]  pid_chn_i;
    logic [DATA_WIDTH-1:0] pid_data_i;

    modport master (output pid_valid_i, pid_chn_i, pid_data_i);
    modport slave  (input  pid_valid_i, pid_chn_i, pid_data_i);

endinterface

// File: rtl/pwm_channel.sv
// One motor channel: shadow command, period-aligned active duty/dir with
// reversal dead time, command watchdog and registered PWM compare.
module pwm_channel
    import pid_out_pkg::*;
#(
    parameter int PWM_MAX         = 1023,
    parameter int DEAD_PERIODS    = 2,
    parameter int TIMEOUT_PERIODS = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  boundary,
    input  logic [PWM_WIDTH-1:0]  cnt,
    output logic                  pwm,
    output logic                  dir,
    output logic                  timeout
);
    localparam int DC_W = $clog2(DEAD_PERIODS + 1);
    localparam int WD_W = $clog2(TIMEOUT_PERIODS + 1);

    logic                 sh_sign;
    logic [PWM_WIDTH-1:0] sh_mag;
    logic [WD_W-1:0]      wd_cnt;

    chn_state_e           state, state_d;
    logic [PWM_WIDTH-1:0] duty, duty_d;
    logic                 dir_d;
    logic [DC_W-1:0]      dead_cnt, dead_d;

    // A command in the same cycle as expiry wins and keeps the flag low.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_sign <= 1'b0;
            sh_mag  <= '0;
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else if (cmd_valid) begin
            sh_sign <= cmd_data[DATA_WIDTH-1];
            sh_mag  <= sat_abs(cmd_data, PWM_WIDTH'(PWM_MAX));
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else if (boundary && wd_cnt != WD_W'(TIMEOUT_PERIODS)) begin
            if (wd_cnt == WD_W'(TIMEOUT_PERIODS - 1)) begin
                sh_mag  <= '0;
                timeout <= 1'b1;
            end
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    always_comb begin
        state_d = state;
        duty_d  = duty;
        dir_d   = dir;
        dead_d  = dead_cnt;
        if (boundary) begin
            unique case (state)
                RUN: begin
                    if (sh_mag == '0) begin
                        duty_d = '0;
                    end else if (sh_sign == dir) begin
                        duty_d = sh_mag;
                    end else begin
                        duty_d  = '0;
                        dead_d  = '0;
                        state_d = DEAD;
                    end
                end
                DEAD: begin
                    // Reload from the latest shadow, so a flip-back during DEAD is harmless.
                    if (dead_cnt == DC_W'(DEAD_PERIODS - 1)) begin
                        dir_d   = sh_sign;
                        duty_d  = sh_mag;
                        state_d = RUN;
                    end else begin
                        dead_d = dead_cnt + DC_W'(1);
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            duty     <= '0;
            dir      <= 1'b0;
            dead_cnt <= '0;
            pwm      <= 1'b0;
        end else begin
            state    <= state_d;
            duty     <= duty_d;
            dir      <= dir_d;
            dead_cnt <= dead_d;
            pwm      <= (cnt < duty);
        end
    end

endmodule

// File: rtl/pid_output_processor.sv
// Converts the PID command stream into per-motor PWM/DIR pairs sharing one
// free-running period counter.
module pid_output_processor
    import pid_out_pkg::*;
#(
    parameter int NUM_CHN         = 4,
    parameter int PWM_MAX         = 1023,
    parameter int DEAD_PERIODS    = 2,
    parameter int TIMEOUT_PERIODS = 100
) (
    input  logic                        clk,
    input  logic                        rst,
    pid_output_processor_if.slave       cmd,
    output logic [NUM_CHN-1:0]          pwm_o,
    output logic [NUM_CHN-1:0]          dir_o,
    output logic [NUM_CHN-1:0]          timeout_o,
    output logic                        period_start_o
);
    logic [PWM_WIDTH-1:0] cnt;
    logic                 boundary;

    assign boundary = (cnt == PWM_WIDTH'(PWM_MAX));

    // period_start_o is registered so it is high exactly while cnt == 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            period_start_o <= 1'b0;
        end else begin
            cnt            <= boundary ? '0 : cnt + PWM_WIDTH'(1);
            period_start_o <= boundary;
        end
    end

    for (genvar n = 0; n < NUM_CHN; n++) begin : g_chn
        logic sel;
        assign sel = cmd.pid_valid_i && (cmd.pid_chn_i == CHN_WIDTH'(n));

        pwm_channel #(
            .PWM_MAX        (PWM_MAX),
            .DEAD_PERIODS   (DEAD_PERIODS),
            .TIMEOUT_PERIODS(TIMEOUT_PERIODS)
        ) u_chn (
            .clk      (clk),
            .rst      (rst),
            .cmd_valid(sel),
            .cmd_data (cmd.pid_data_i),
            .boundary (boundary),
            .cnt      (cnt),
            .pwm      (pwm_o[n]),
            .dir      (dir_o[n]),
            .timeout  (timeout_o[n])
        );
    end

endmodule

// File: tb/tb_pid_output_processor.sv
// Directed bench for pid_output_processor; watchdog shortened to 16 periods to
// keep the run short.
module tb_pid_output_processor;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] pwm_o, dir_o, timeout_o;
    logic       period_start_o;

    int         checks = 0;
    int         errors = 0;
    int         hi [4];
    logic [3:0] dsamp;

    always #5 clk = ~clk;

    pid_output_processor_if bus ();

    pid_output_processor #(
        .NUM_CHN        (4),
        .PWM_MAX        (1023),
        .DEAD_PERIODS   (2),
        .TIMEOUT_PERIODS(16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd           (bus),
        .pwm_o         (pwm_o),
        .dir_o         (dir_o),
        .timeout_o     (timeout_o),
        .period_start_o(period_start_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int c, input int d);
        bus.pid_valid_i = 1'b1;
        bus.pid_chn_i   = 3'(c);
        bus.pid_data_i  = 16'(d);
        @(posedge clk);
        #1;
        bus.pid_valid_i = 1'b0;
    endtask

    // Advance to the next negedge where period_start_o is high (cnt == 0).
    task automatic sync_ps();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start_o && n < 2100);
        if (!period_start_o) begin
            checks++;
            errors++;
            $error("FAIL sync: period_start_o not seen within 2100 cycles");
        end
    endtask

    // Count high cycles of every channel over one period (cnt 0..1023 of pwm).
    task automatic measure(input bit resync);
        if (resync) sync_ps();
        for (int c = 0; c < 4; c++) hi[c] = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (i == 0) dsamp = dir_o;
            for (int c = 0; c < 4; c++) hi[c] += int'(pwm_o[c]);
        end
    endtask

    task automatic check_hi(input string tag, input int e0, input int e1, input int e2, input int e3);
        chk({tag, " hi0"}, hi[0], e0);
        chk({tag, " hi1"}, hi[1], e1);
        chk({tag, " hi2"}, hi[2], e2);
        chk({tag, " hi3"}, hi[3], e3);
    endtask

    initial begin
        bus.pid_valid_i = 1'b0;
        bus.pid_chn_i   = '0;
        bus.pid_data_i  = '0;
        rst             = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset pwm", pwm_o, 4'b0000);
        chk("reset dir", dir_o, 4'b0000);
        chk("reset timeout", timeout_o, 4'b0000);
        chk("reset period_start", period_start_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // P0 command, P1 applied: 50% duty forward
        send(0, 512);
        measure(1);
        check_hi("p1", 512, 0, 0, 0);
        chk("p1 dir", dsamp, 4'b0000);

        // Saturated reverse: two dead periods, then 1023
        send(1, -2000);
        measure(1);
        check_hi("p3", 512, 0, 0, 0);
        chk("p3 dir", dsamp, 4'b0000);
        measure(0);
        chk("p4 hi1", hi[1], 0);
        chk("p4 dir", dsamp, 4'b0000);
        measure(0);
        chk("p5 hi1", hi[1], 1023);
        chk("p5 dir", dsamp, 4'b0010);

        // Same-period overwrite across direction takes the DEAD path
        send(2, 300);
        send(2, -300);
        measure(1);
        chk("p7 hi2", hi[2], 0);
        chk("p7 dir", dsamp, 4'b0010);
        measure(0);
        chk("p8 hi2", hi[2], 0);
        measure(0);
        chk("p9 hi2", hi[2], 300);
        chk("p9 dir", dsamp, 4'b0110);

        // Same-direction overwrite: latest wins at the next boundary
        send(0, 100);
        send(0, 200);
        measure(1);
        check_hi("p11", 200, 1023, 300, 0);

        // Out-of-range channel is ignored
        send(5, -50);
        measure(1);
        check_hi("p13", 200, 1023, 300, 0);
        chk("p13 dir", dsamp, 4'b0110);

        // Command landing on the boundary cycle applies one period later
        repeat (1023) @(negedge clk);
        send(0, 600);
        measure(1);
        chk("p15 hi0", hi[0], 200);
        measure(0);
        chk("p16 hi0", hi[0], 600);

        // Watchdog on ch3 (other channels expire along the way)
        send(3, 400);
        measure(1);
        check_hi("p18", 600, 1023, 300, 400);
        chk("p19 timeout", timeout_o, 4'b0010);
        repeat (13) sync_ps();
        chk("p32 timeout", timeout_o, 4'b0111);
        sync_ps();
        chk("p33 timeout", timeout_o, 4'b1111);
        measure(1);
        check_hi("p34", 0, 0, 0, 0);
        chk("p34 dir", dsamp, 4'b0110);
        send(3, 50);
        chk("ch3 timeout clear", timeout_o, 4'b0111);
        measure(1);
        check_hi("p36", 0, 0, 0, 50);

        // Reset while ch1 sits in DEAD and ch0 is driving high
        send(1, 300);
        send(0, 900);
        sync_ps();
        repeat (500) @(negedge clk);
        chk("pre-rst pwm", pwm_o, 4'b0001);
        chk("pre-rst dir", dir_o, 4'b0110);
        chk("pre-rst timeout", timeout_o, 4'b0100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst pwm", pwm_o, 4'b0000);
        chk("rst dir", dir_o, 4'b0000);
        chk("rst timeout", timeout_o, 4'b0000);
        chk("rst period_start", period_start_o, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(1, 200);
        measure(1);
        check_hi("post-rst", 0, 200, 0, 0);
        chk("post-rst dir", dsamp, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
